// File: rtl/rr_grant_scheduler_if.sv
// rr_grant_scheduler_if: request/grant bundle between requesters and the
// round-robin scheduler. The scheduler sits on the slave side.
interface rr_grant_scheduler_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    // Requester side: raises requests, observes the grant.
    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    // Scheduler side: observes requests, drives the grant.
    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: N-way round-robin arbiter for one shared resource.
// Grants are registered one-hot with a binary owner index. An owner keeps the
// grant while it holds req, until HOLD_MAX consecutive cycles have elapsed and
// someone else is waiting; every withdrawal is followed by one bubble cycle.
module rr_grant_scheduler #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int HOLD_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    rr_grant_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [N-1:0]     ONE_HOT0 = N'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N);
    // Hold counter ceiling; with HOLD_MAX == 0 it just parks at its maximum.
    localparam logic [4:0]       CNT_CAP  = (HOLD_MAX == 0) ? 5'd31 : 5'(HOLD_MAX - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [4:0]       cnt, cnt_nxt;
    logic [N-1:0]     gnt_q, gnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             valid_q, valid_nxt;
    logic             preempt_q, preempt_nxt;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   sum;
    logic             owner_req;
    logic             others_req;
    logic             hold_hit;
    logic [IDX_W-1:0] after_owner;

    // Round-robin search: first requester at or after ptr, wrapping mod N.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips the assignment infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            cand = sum[IDX_W-1:0];
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The registered grant doubles as the owner mask, and idx_q as the owner.
    assign owner_req   = |(bus.req & gnt_q);
    assign others_req  = |(bus.req & ~gnt_q);
    assign hold_hit    = (HOLD_MAX != 0) && (cnt == CNT_CAP) && others_req;
    assign after_owner = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    // State register plus all registered outputs; reset drops the grant at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            gnt_q     <= gnt_nxt;
            idx_q     <= idx_nxt;
            valid_q   <= valid_nxt;
            preempt_q <= preempt_nxt;
        end
    end

    // Next-state: the bubble cycle arbitrates exactly like IDLE on its way out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RELEASE: state_nxt = win_found ? GRANT : IDLE;
            GRANT:         state_nxt = (!owner_req || hold_hit) ? RELEASE : GRANT;
            default:       state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values: grant on a win, withdraw on drop or hold limit.
    always_comb begin
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt_q;
        idx_nxt     = idx_q;
        valid_nxt   = valid_q;
        preempt_nxt = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                if (win_found) begin
                    gnt_nxt   = ONE_HOT0 << win_idx;
                    idx_nxt   = win_idx;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!owner_req || hold_hit) begin
                    gnt_nxt     = '0;
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    ptr_nxt     = after_owner;
                    // A voluntary drop is not a preemption.
                    preempt_nxt = owner_req;
                end else if (cnt != CNT_CAP) begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            default: begin
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.preempt   = preempt_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.gnt));
    a_idx_matches: assert property (@(posedge clk) disable iff (reset)
        bus.gnt_valid ? (bus.gnt == (ONE_HOT0 << bus.gnt_idx)) : (bus.gnt_idx == '0));
    a_valid_is_or: assert property (@(posedge clk) disable iff (reset)
        bus.gnt_valid == (|bus.gnt));
    a_preempt_idle: assert property (@(posedge clk) disable iff (reset)
        !bus.preempt || (bus.gnt == '0));

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed bench for the round-robin scheduler built
// with HOLD_MAX=4 so the preemption path is short enough to walk by hand.
module tb_rr_grant_scheduler;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   w;
    logic [7:0] exp_gnt;

    rr_grant_scheduler_if #(.N(8), .IDX_W(3)) bus ();

    rr_grant_scheduler #(.N(8), .IDX_W(3), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packs {gnt, gnt_idx, gnt_valid, preempt}; index and valid follow from gnt.
    task automatic expect_state(input string tag, input logic [7:0] g, input logic p);
        logic [2:0] ei;
        ei = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) ei = 3'(i);
        end
        check(tag, {19'b0, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt},
                   {19'b0, g, ei, |g, p});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        bus.req = 8'h00;
        tick();
        tick();
        expect_state("reset", 8'h00, 1'b0);
        reset = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state($sformatf("idle%0d", i), 8'h00, 1'b0);
        end

        // Single requester 2 for 4 cycles, then drop: ptr ends at 3.
        bus.req = 8'b0000_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state($sformatf("single2_c%0d", i + 1), 8'b0000_0100, 1'b0);
        end
        bus.req = 8'h00;
        tick();
        expect_state("single2_drop", 8'h00, 1'b0);
        tick();
        expect_state("single2_idle", 8'h00, 1'b0);

        // Bits 2 and 7: ptr=3 must pick 7; then reset mid-grant.
        bus.req = 8'b1000_0100;
        tick();
        expect_state("ptr3_pick7", 8'b1000_0000, 1'b0);
        reset = 1'b1;
        #1;
        expect_state("reset_mid_grant", 8'h00, 1'b0);
        bus.req = 8'h00;
        tick();
        reset = 1'b0;
        tick();
        expect_state("after_reset", 8'h00, 1'b0);

        // All request; each owner drops after 2 cycles: order 0..7,0.
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            w       = i % 8;
            exp_gnt = 8'h01 << w;
            tick();
            expect_state($sformatf("rr%0d_c1", i), exp_gnt, 1'b0);
            tick();
            expect_state($sformatf("rr%0d_c2", i), exp_gnt, 1'b0);
            bus.req[w] = 1'b0;
            tick();
            expect_state($sformatf("rr%0d_bubble", i), 8'h00, 1'b0);
            bus.req = (i < 8) ? 8'hFF : 8'h00;
        end
        tick();
        expect_state("rr_idle", 8'h00, 1'b0);

        // Walk ptr to 6 via a grant to 5.
        bus.req = 8'b0010_0000;
        tick();
        expect_state("to6_g5", 8'b0010_0000, 1'b0);
        bus.req = 8'h00;
        tick();
        expect_state("to6_bubble", 8'h00, 1'b0);

        // From ptr=6: bits 6 and 0 -> 6; then only 0 -> wrap to 0.
        bus.req = 8'b0100_0001;
        tick();
        expect_state("wrap_g6", 8'b0100_0000, 1'b0);
        bus.req = 8'b0000_0001;
        tick();
        expect_state("wrap_bubble", 8'h00, 1'b0);
        tick();
        expect_state("wrap_g0", 8'b0000_0001, 1'b0);
        bus.req = 8'h00;
        tick();
        expect_state("wrap_drop", 8'h00, 1'b0);
        tick();
        expect_state("wrap_idle", 8'h00, 1'b0);

        // Hold limit 4: bits 1 and 5 held, ptr=1.
        bus.req = 8'b0010_0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state($sformatf("hold_g1_c%0d", i + 1), 8'b0000_0010, 1'b0);
        end
        tick();
        expect_state("hold_pre1", 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state($sformatf("hold_g5_c%0d", i + 1), 8'b0010_0000, 1'b0);
        end
        tick();
        expect_state("hold_pre5", 8'h00, 1'b1);
        tick();
        expect_state("hold_back1", 8'b0000_0010, 1'b0);
        bus.req = 8'h00;
        tick();
        expect_state("hold_drop", 8'h00, 1'b0);
        tick();
        expect_state("hold_idle", 8'h00, 1'b0);

        // Lone requester 3 for 20 cycles: never preempted.
        bus.req = 8'b0000_1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_state($sformatf("lone3_c%0d", i + 1), 8'b0000_1000, 1'b0);
        end
        bus.req = 8'h00;
        tick();
        expect_state("lone3_drop", 8'h00, 1'b0);
        tick();
        expect_state("lone3_idle", 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
